// File: rtl/fpga_btn_debounce.sv
// Debounce and synchronise raw board inputs (buttons, switches) before they
// reach the SoC pad frame. Each channel runs a 2-flop synchroniser, a
// stability counter and a registered clean level with one-cycle edge pulses.
module fpga_btn_debounce #(
  parameter int unsigned N_INPUTS        = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic                ref_clk,
  input  logic                ref_rst,
  input  logic [N_INPUTS-1:0] raw_i,
  output logic [N_INPUTS-1:0] clean_o,
  output logic [N_INPUTS-1:0] rise_o,
  output logic [N_INPUTS-1:0] fall_o
);

  // Count value on which a differing synchronised level is finally accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [N_INPUTS-1:0]  sync1_q, sync1_d;
  logic [N_INPUTS-1:0]  sync2_q, sync2_d;
  logic [N_INPUTS-1:0]  clean_q, clean_d;
  logic [N_INPUTS-1:0]  rise_q,  rise_d;
  logic [N_INPUTS-1:0]  fall_q,  fall_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_INPUTS];
  logic [CNT_WIDTH-1:0] cnt_d [N_INPUTS];

  // Next-state: synchroniser shift, per-channel stability count and edge pulses.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it
    // unassigned; otherwise the tool would infer a latch.
    sync1_d = raw_i;
    sync2_d = sync1_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Level has been stable long enough: accept it and flag the edge.
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
      // Matching level (or a one-cycle glitch back) leaves cnt_d at zero,
      // which restarts the stability window.
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge ref_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (ref_rst) begin
      sync1_q <= {N_INPUTS{RESET_VALUE}};
      sync2_q <= {N_INPUTS{RESET_VALUE}};
      clean_q <= {N_INPUTS{RESET_VALUE}};
      rise_q  <= '0;
      fall_q  <= '0;
      // NOTE: the counter bank is a handful of flops, not a RAM, so it is
      // reset explicitly; a reset mid-count must discard the partial count.
      for (int i = 0; i < N_INPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N_INPUTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: tb/tb_fpga_btn_debounce.sv
// Directed testbench for fpga_btn_debounce with a short debounce window.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_fpga_btn_debounce;

  localparam int unsigned N  = 7;
  localparam int unsigned DC = 4;

  logic         ref_clk = 1'b0;
  logic         ref_rst = 1'b1;
  logic [N-1:0] raw_i   = '0;
  logic [N-1:0] clean_o, rise_o, fall_o;

  int n_cmp = 0;
  int n_bad = 0;

  fpga_btn_debounce #(
    .N_INPUTS       (N),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (3),
    .RESET_VALUE    (1'b0)
  ) dut (
    .ref_clk(ref_clk),
    .ref_rst(ref_rst),
    .raw_i  (raw_i),
    .clean_o(clean_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  always #5 ref_clk = ~ref_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  // Reset with all inputs high; rising pulses on every channel at F+5.
  task automatic test_reset();
    logic [N-1:0] ec, er;
    raw_i   = 7'h7F;
    ref_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ref_clk);
      n_cmp++;
      if (clean_o !== 7'h00 || rise_o !== 7'h00 || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL reset_hold k=%0d got c=%h r=%h f=%h want c=00 r=00 f=00",
                 k, clean_o, rise_o, fall_o);
      end
    end
    ref_rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge ref_clk);
      ec = (k >= 5) ? 7'h7F : 7'h00;
      er = (k == 5) ? 7'h7F : 7'h00;
      n_cmp++;
      if (clean_o !== ec || rise_o !== er || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL reset_release k=%0d got c=%h r=%h f=%h want c=%h r=%h f=00",
                 k, clean_o, rise_o, fall_o, ec, er);
      end
    end
  endtask

  // Channels 1 and 4 released together: concurrent falls at E0+5.
  task automatic test_release_simultaneous();
    logic [N-1:0] ec, ef;
    raw_i = 7'h6D;
    for (int k = 0; k <= 6; k++) begin
      @(negedge ref_clk);
      ec = (k >= 5) ? 7'h6D : 7'h7F;
      ef = (k == 5) ? 7'h12 : 7'h00;
      n_cmp++;
      if (clean_o !== ec || rise_o !== 7'h00 || fall_o !== ef) begin
        n_bad++;
        $display("FAIL release_1_4 k=%0d got c=%h r=%h f=%h want c=%h r=00 f=%h",
                 k, clean_o, rise_o, fall_o, ec, ef);
      end
    end
  endtask

  // Drop the remaining channels so the following tests start from all-low.
  task automatic test_release_rest();
    logic [N-1:0] ec, ef;
    raw_i = 7'h00;
    for (int k = 0; k <= 6; k++) begin
      @(negedge ref_clk);
      ec = (k >= 5) ? 7'h00 : 7'h6D;
      ef = (k == 5) ? 7'h6D : 7'h00;
      n_cmp++;
      if (clean_o !== ec || rise_o !== 7'h00 || fall_o !== ef) begin
        n_bad++;
        $display("FAIL release_rest k=%0d got c=%h r=%h f=%h want c=%h r=00 f=%h",
                 k, clean_o, rise_o, fall_o, ec, ef);
      end
    end
  endtask

  // Clean press on channel 0: one-cycle rise at E0+5, other bits untouched.
  task automatic test_clean_press();
    logic [N-1:0] ec, er;
    raw_i = 7'h01;
    for (int k = 0; k <= 6; k++) begin
      @(negedge ref_clk);
      ec = (k >= 5) ? 7'h01 : 7'h00;
      er = (k == 5) ? 7'h01 : 7'h00;
      n_cmp++;
      if (clean_o !== ec || rise_o !== er || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL clean_press k=%0d got c=%h r=%h f=%h want c=%h r=%h f=00",
                 k, clean_o, rise_o, fall_o, ec, er);
      end
    end
  endtask

  // Channel 2 bounces 1,0,1,0 then settles high: single rise at E0+5.
  task automatic test_bounce();
    logic [N-1:0] ec, er;
    for (int j = 0; j < 4; j++) begin
      raw_i[2] = (j % 2 == 0);
      @(negedge ref_clk);
      n_cmp++;
      if (clean_o !== 7'h01 || rise_o !== 7'h00 || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL bounce_toggle j=%0d got c=%h r=%h f=%h want c=01 r=00 f=00",
                 j, clean_o, rise_o, fall_o);
      end
    end
    raw_i[2] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge ref_clk);
      ec = (k >= 5) ? 7'h05 : 7'h01;
      er = (k == 5) ? 7'h04 : 7'h00;
      n_cmp++;
      if (clean_o !== ec || rise_o !== er || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL bounce_settle k=%0d got c=%h r=%h f=%h want c=%h r=%h f=00",
                 k, clean_o, rise_o, fall_o, ec, er);
      end
    end
  endtask

  // Channel 3 high for DEBOUNCE_CYCLES-1 cycles: counter peaks but never accepts.
  task automatic test_short_glitch();
    raw_i[3] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge ref_clk);
      if (k == 2) raw_i[3] = 1'b0;
      n_cmp++;
      if (clean_o !== 7'h05 || rise_o !== 7'h00 || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL short_glitch k=%0d got c=%h r=%h f=%h want c=05 r=00 f=00",
                 k, clean_o, rise_o, fall_o);
      end
    end
  endtask

  // Channel 5 mid-count when reset pulses: partial count is discarded and
  // reset itself produces no pulses even though clean drops to 0.
  task automatic test_reset_mid_count();
    logic [N-1:0] ec, er;
    raw_i[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ref_clk);
      n_cmp++;
      if (clean_o !== 7'h05 || rise_o !== 7'h00 || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL midreset_pre k=%0d got c=%h r=%h f=%h want c=05 r=00 f=00",
                 k, clean_o, rise_o, fall_o);
      end
    end
    ref_rst = 1'b1;
    @(negedge ref_clk);
    n_cmp++;
    if (clean_o !== 7'h00 || rise_o !== 7'h00 || fall_o !== 7'h00) begin
      n_bad++;
      $display("FAIL midreset_in got c=%h r=%h f=%h want c=00 r=00 f=00",
               clean_o, rise_o, fall_o);
    end
    ref_rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge ref_clk);
      ec = (k >= 5) ? 7'h25 : 7'h00;
      er = (k == 5) ? 7'h25 : 7'h00;
      n_cmp++;
      if (clean_o !== ec || rise_o !== er || fall_o !== 7'h00) begin
        n_bad++;
        $display("FAIL midreset_post k=%0d got c=%h r=%h f=%h want c=%h r=%h f=00",
                 k, clean_o, rise_o, fall_o, ec, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release_simultaneous();
    test_release_rest();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
